seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
Parametrised, registered successor of the 4-bit switch-driven combinational ALU.
- Accepts one operation per valid/ready handshake and returns a registered result with flags through a second valid/ready handshake.
- Adds carry-in add, shifts, and iterative multiply/divide/remainder.
- Sits between the board I/O wrapper (switches/buttons) and the LED/seven-segment display logic; also reusable as a datapath unit in later CPU labs.

Parameters:
W, 8, operand/result width in bits (W >= 2).
SHW, $clog2(W), shift-amount field width (derived, not overridden).

Ports:
clk  in  1  rising-edge clock
rst  in  1  reset, synchronous, active-high
in_valid  in  1  operation request present
in_ready  out  1  block can accept request
op  in  4  operation code (see Behaviour)
a  in  W  operand A
b  in  W  operand B
cin  in  1  carry-in, used only by ADC
out_valid  out  1  result registers hold an unconsumed result
out_ready  in  1  consumer takes result
result  out  W  operation result
carry  out  1  carry out / no-borrow
overflow  out  1  signed overflow, MUL high-part nonzero, or divide-by-zero
zero  out  1  result == 0

Behaviour:
- Opcodes: 0 ADD, 1 SUB, 2 NOT(a), 3 AND, 4 OR, 5 XOR, 6 LT, 7 EQ, 8 ADC, 9 SLL, A SRL, B SRA, C MUL, D DIVU, E REMU, F illegal.
- Operands are captured on acceptance, when in_valid && in_ready. Inputs are ignored at all other times.
- FSM states:
  - IDLE: in_ready=1.
  - BUSY: iterative op running, in_ready=0.
  - DONE: out_valid=1, in_ready=0.
- Transitions:
  - IDLE, accept single-cycle op -> DONE next cycle. Latency 1 cycle from acceptance to out_valid.
  - IDLE, accept C/D/E -> BUSY. Iteration counter loads W-1 and decrements each cycle; BUSY -> DONE when it reaches 0. out_valid rises exactly W+1 cycles after acceptance.
  - DONE, out_ready=1 -> IDLE. There is no same-cycle re-accept, so peak throughput is one single-cycle op per 2 clocks.
  - DONE, out_ready=0 -> hold. result and flags stay stable until consumed.
- Arithmetic:
  - ADD/ADC/SUB use a (W+1)-bit sum: a + b + cin for ADC, a + b for ADD, a + ~b + 1 for SUB.
  - carry = bit W of that sum. For SUB, carry=1 means no borrow (a >= b unsigned).
  - overflow = (a[W-1]==b'[W-1]) && (sum[W-1]!=a[W-1]), where b' is the effective addend.
  - LT: signed a<b, computed as sub_sum[W-1] ^ sub_overflow; result = {0..,lt}.
  - EQ: result = {0..,a==b}.
- Shifts use b[SHW-1:0]; upper bits of b are ignored. SRA sign-fills.
- MUL:
  - Unsigned shift-add, one partial product per cycle.
  - result = low W bits.
  - overflow = 1 if the high W bits are nonzero.
- DIVU/REMU:
  - Unsigned restoring division, one quotient bit per cycle.
  - Divide by zero: quotient = all ones, remainder = a, overflow=1. Still takes W+1 cycles.
- Flags:
  - carry and overflow are 0 for ops that do not define them.
  - zero is valid for every op.
- Illegal op F: result=0, all flags 0 except zero=1. Completes in 1 cycle.
- Reset:
  - State -> IDLE.
  - result, carry, overflow, zero, out_valid, counter -> 0.
  - in_ready reads 1 the cycle after rst deasserts.
  - rst during BUSY or DONE aborts the operation and discards the result.
- Simultaneous events: rst has priority over handshakes. in_valid while BUSY or DONE is not accepted; the requester must hold it.

Decomposition:
- Package alu_pkg: op enum (ALU_ADD..ALU_ILL, 4-bit), FSM state enum, helper function for the signed-overflow expression.
- One sub-module alu_iter_muldiv (W parameter). Shared accumulator/shift datapath for MUL/DIVU/REMU, with start/done pulses and hi/lo outputs.
- Top holds the FSM, the single-cycle combinational ops, and the output registers.

Test Plan:
1. W=8, ADD a=0x7F b=0x01 -> result 0x80, overflow=1, carry=0, zero=0, out_valid 1 cycle after accept.
2. SUB a=0x03 b=0x05 -> 0xFE, carry=0. Then LT on the same operands -> 0x01. LT a=0x80 b=0x7F -> 0x01 (signed).
3. ADC a=0xFF b=0x00 cin=1 -> 0x00, carry=1, zero=1. SRA a=0x90 b=0x0B (uses 3 bits = 3) -> 0xF2.
4. MUL a=0x12 b=0x10 -> 0x20, overflow=1, out_valid exactly 9 cycles after accept. DIVU 200/7 -> 0x1C. REMU 200/7 -> 0x04.
5. DIVU a=0x2A b=0 -> 0xFF, overflow=1. REMU a=0x2A b=0 -> 0x2A, overflow=1.
6. Backpressure and reset:
   - Hold out_ready=0 for 5 cycles -> result stable, in_ready=0, a second in_valid is not accepted.
   - Assert rst mid-MUL (cycle 4) -> out_valid=0, all outputs 0, in_ready=1 the cycle after rst drops.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and helpers for the sequential ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_NOT  = 4'h2,
    ALU_AND  = 4'h3,
    ALU_OR   = 4'h4,
    ALU_XOR  = 4'h5,
    ALU_LT   = 4'h6,
    ALU_EQ   = 4'h7,
    ALU_ADC  = 4'h8,
    ALU_SLL  = 4'h9,
    ALU_SRL  = 4'hA,
    ALU_SRA  = 4'hB,
    ALU_MUL  = 4'hC,
    ALU_DIVU = 4'hD,
    ALU_REMU = 4'hE,
    ALU_ILL  = 4'hF
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  // Two's-complement overflow of an addition from the operand and sum sign bits.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  // Ops served by the multi-cycle multiply/divide datapath.
  function automatic logic is_iter(input alu_op_e op);
    return op inside {ALU_MUL, ALU_DIVU, ALU_REMU};
  endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative unsigned multiply / restoring divide, one bit per cycle.
// Ports: start loads a/b and performs the first step; done pulses for one
// cycle once hi/lo hold the final value (MUL: {hi,lo} = a*b; DIV: lo =
// quotient, hi = remainder; divide by zero naturally yields lo = all ones,
// hi = a).
module alu_iter_muldiv #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         div_mode,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         done,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  localparam int unsigned CW = $clog2(W);

  logic [W-1:0]  hi_q, lo_q, aux_q;
  logic          div_q, run_q, done_q;
  logic [CW-1:0] cnt_q;

  logic [W-1:0]  cur_hi, cur_lo, cur_aux, nxt_hi, nxt_lo;
  logic          cur_div, ge;
  logic [W:0]    mul_sum, div_sh;

  // One step of the selected algorithm; on start it operates on freshly loaded operands.
  always_comb begin
    cur_hi  = start ? '0 : hi_q;
    cur_lo  = start ? a : lo_q;
    cur_aux = start ? b : aux_q;
    cur_div = start ? div_mode : div_q;

    mul_sum = {1'b0, cur_hi} + (cur_lo[0] ? {1'b0, cur_aux} : '0);
    div_sh  = {cur_hi, cur_lo[W-1]};
    ge      = div_sh >= {1'b0, cur_aux};

    if (cur_div) begin
      nxt_hi = ge ? W'(div_sh - {1'b0, cur_aux}) : div_sh[W-1:0];
      nxt_lo = {cur_lo[W-2:0], ge};
    end else begin
      nxt_hi = mul_sum[W:1];
      nxt_lo = {mul_sum[0], cur_lo[W-1:1]};
    end
  end

  // Step counter loads W-1 on start; the last step happens when it reads 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q   <= '0;
      lo_q   <= '0;
      aux_q  <= '0;
      div_q  <= 1'b0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (start || run_q) begin
        hi_q <= nxt_hi;
        lo_q <= nxt_lo;
      end
      if (start) begin
        aux_q <= b;
        div_q <= div_mode;
        run_q <= 1'b1;
        cnt_q <= CW'(W - 1);
      end else if (run_q) begin
        cnt_q <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with valid/ready request and result handshakes.
// Ports: in_valid/in_ready accept {op,a,b,cin}; out_valid/out_ready
// return {result,carry,overflow,zero}. Single-cycle ops produce a result
// one cycle after acceptance; MUL/DIVU/REMU take W+1 cycles.
module seq_alu
  import alu_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         carry,
  output logic         overflow,
  output logic         zero
);

  localparam int unsigned SHW = $clog2(W);

  alu_state_e   state_q, state_d;
  alu_op_e      op_e, op_q;
  logic         bz_q;
  logic         it_start, load_sc, load_it;
  logic         it_done;
  logic [W-1:0] it_hi, it_lo, it_res;
  logic         it_ovf;

  logic [W-1:0]   b_eff, sc_res;
  logic           cin_eff, sum_ovf, sc_carry, sc_ovf;
  logic [W:0]     sum;
  logic [SHW-1:0] sh;

  assign op_e = alu_op_e'(op);

  // Single-cycle ops; SUB and LT share the adder with an inverted addend.
  always_comb begin
    b_eff   = b;
    cin_eff = 1'b0;
    if (op_e == ALU_SUB || op_e == ALU_LT) begin
      b_eff   = ~b;
      cin_eff = 1'b1;
    end else if (op_e == ALU_ADC) begin
      cin_eff = cin;
    end
    sum     = {1'b0, a} + {1'b0, b_eff} + (W+1)'(cin_eff);
    sum_ovf = add_ovf(a[W-1], b_eff[W-1], sum[W-1]);
    sh      = b[SHW-1:0];

    sc_res   = '0;
    sc_carry = 1'b0;
    sc_ovf   = 1'b0;
    case (op_e)
      ALU_ADD, ALU_SUB, ALU_ADC: begin
        sc_res   = sum[W-1:0];
        sc_carry = sum[W];
        sc_ovf   = sum_ovf;
      end
      ALU_NOT: sc_res = ~a;
      ALU_AND: sc_res = a & b;
      ALU_OR:  sc_res = a | b;
      ALU_XOR: sc_res = a ^ b;
      ALU_LT:  sc_res = W'(sum[W-1] ^ sum_ovf);
      ALU_EQ:  sc_res = W'(a == b);
      ALU_SLL: sc_res = a << sh;
      ALU_SRL: sc_res = a >> sh;
      ALU_SRA: sc_res = W'($signed(a) >>> sh);
      default: sc_res = '0;
    endcase
  end

  alu_iter_muldiv #(.W(W)) u_iter (
    .clk      (clk),
    .rst      (rst),
    .start    (it_start),
    .div_mode (op_e != ALU_MUL),
    .a        (a),
    .b        (b),
    .done     (it_done),
    .hi       (it_hi),
    .lo       (it_lo)
  );

  // Select the multi-cycle result; divide-by-zero was noted at acceptance.
  always_comb begin
    it_res = it_lo;
    it_ovf = bz_q;
    case (op_q)
      ALU_MUL:  begin it_res = it_lo; it_ovf = |it_hi; end
      ALU_REMU: begin it_res = it_hi; it_ovf = bz_q;   end
      default:  begin it_res = it_lo; it_ovf = bz_q;   end
    endcase
  end

  // Next-state and load strobes.
  always_comb begin
    state_d  = state_q;
    it_start = 1'b0;
    load_sc  = 1'b0;
    load_it  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (is_iter(op_e)) begin
            it_start = 1'b1;
            state_d  = ST_BUSY;
          end else begin
            load_sc = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_BUSY: begin
        if (it_done) begin
          load_it = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, handshake flags and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      op_q      <= ALU_ADD;
      bz_q      <= 1'b0;
      result    <= '0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_ready  <= (state_d == ST_IDLE);
      out_valid <= (state_d == ST_DONE);
      if (it_start) begin
        op_q <= op_e;
        bz_q <= (b == '0);
      end
      if (load_sc) begin
        result   <= sc_res;
        carry    <= sc_carry;
        overflow <= sc_ovf;
        zero     <= (sc_res == '0);
      end else if (load_it) begin
        result   <= it_res;
        carry    <= 1'b0;
        overflow <= it_ovf;
        zero     <= (it_res == '0);
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: arithmetic reference model with per-cycle compare,
// plus directed vectors with literal expectations.
module tb_seq_alu;

  localparam int unsigned W = 8;
  localparam int M = 256;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic         cin = 1'b0;
  logic [3:0]   op = 4'h0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, out_valid, carry, overflow, zero;
  logic [W-1:0] result;

  seq_alu #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry),
    .overflow  (overflow),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int res;
    bit c;
    bit v;
    bit z;
    int lat;
    int acc;
  } exp_t;

  exp_t q[$];
  exp_t e, n;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit out_rng(input int x);
    return (x < -(M/2)) || (x > M/2 - 1);
  endfunction

  // Reference behaviour from plain integer arithmetic.
  function automatic exp_t model(input int o, input int ua, input int ub, input int ci);
    exp_t r;
    int sa, sb, s, sh;
    sa = (ua >= M/2) ? ua - M : ua;
    sb = (ub >= M/2) ? ub - M : ub;
    sh = ub % int'(W);
    r.res = 0; r.c = 0; r.v = 0; r.lat = 1; r.acc = 0;
    case (o)
      0:  begin s = ua + ub; r.res = s % M; r.c = (s >= M); r.v = out_rng(sa + sb); end
      1:  begin r.res = (ua - ub + M) % M; r.c = (ua >= ub); r.v = out_rng(sa - sb); end
      2:  r.res = M - 1 - ua;
      3:  r.res = ua & ub;
      4:  r.res = ua | ub;
      5:  r.res = ua ^ ub;
      6:  r.res = (sa < sb) ? 1 : 0;
      7:  r.res = (ua == ub) ? 1 : 0;
      8:  begin s = ua + ub + ci; r.res = s % M; r.c = (s >= M); r.v = out_rng(sa + sb + ci); end
      9:  r.res = (ua << sh) % M;
      10: r.res = ua >> sh;
      11: r.res = (sa >>> sh) & (M - 1);
      12: begin s = ua * ub; r.res = s % M; r.v = (s >= M); r.lat = W + 1; end
      13: begin r.lat = W + 1; if (ub == 0) begin r.res = M - 1; r.v = 1; end else r.res = ua / ub; end
      14: begin r.lat = W + 1; if (ub == 0) begin r.res = ua; r.v = 1; end else r.res = ua % ub; end
      default: r.res = 0;
    endcase
    r.z = (r.res == 0);
    return r;
  endfunction

  // Per-cycle compare against the model; inputs and outputs sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
    end else begin
      chk("in_ready", 32'(in_ready), 32'(q.size() == 0));
      if (q.size() == 0) begin
        chk("out_valid_idle", 32'(out_valid), 32'(0));
      end else begin
        e = q[0];
        chk("out_valid_timing", 32'(out_valid), 32'((cyc - e.acc + 1) >= e.lat));
        if (out_valid) begin
          chk("m_result",   32'(result),   32'(e.res));
          chk("m_carry",    32'(carry),    32'(e.c));
          chk("m_overflow", 32'(overflow), 32'(e.v));
          chk("m_zero",     32'(zero),     32'(e.z));
          if (out_ready) void'(q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        n = model(int'(op), int'(a), int'(b), int'(cin));
        n.acc = cyc + 1;
        q.push_back(n);
      end
    end
  end

  task automatic send(input logic [3:0] o, input logic [7:0] xa, input logic [7:0] xb, input logic xc);
    int t;
    @(posedge clk); #1;
    op = o; a = xa; b = xb; cin = xc; in_valid = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!in_ready && t < 50);
    chk("accept", 32'(in_ready), 32'(1));
    @(posedge clk); #1;
    in_valid = 1'b0; op = ~o; a = ~xa; b = ~xb; cin = ~xc;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!out_valid && lat < 60);
  endtask

  task automatic run(input string nm, input logic [3:0] o, input logic [7:0] xa, input logic [7:0] xb,
                     input logic xc, input logic [7:0] er, input logic ec, input logic ev,
                     input logic ez, input int el);
    int lat;
    send(o, xa, xb, xc);
    wait_out(lat);
    chk({nm, "_lat"},  32'(lat),      32'(el));
    chk({nm, "_res"},  32'(result),   32'(er));
    chk({nm, "_c"},    32'(carry),    32'(ec));
    chk({nm, "_v"},    32'(overflow), 32'(ev));
    chk({nm, "_z"},    32'(zero),     32'(ez));
  endtask

  logic [7:0] pa [5] = '{8'h00, 8'hFF, 8'h80, 8'h5A, 8'hC8};
  logic [7:0] pb [5] = '{8'h00, 8'h01, 8'h7F, 8'hA5, 8'h07};

  initial begin
    int lat, t;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready",  32'(in_ready),  32'(1));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_result",    32'(result),    32'(0));
    chk("rst_flags",     32'({carry, overflow, zero}), 32'(0));

    run("add",  4'h0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 1);
    run("sub",  4'h1, 8'h03, 8'h05, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0, 1);
    run("lt1",  4'h6, 8'h03, 8'h05, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 1);
    run("lt2",  4'h6, 8'h80, 8'h7F, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 1);
    run("adc",  4'h8, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1);
    run("sra",  4'hB, 8'h90, 8'h0B, 1'b0, 8'hF2, 1'b0, 1'b0, 1'b0, 1);
    run("mul",  4'hC, 8'h12, 8'h10, 1'b0, 8'h20, 1'b0, 1'b1, 1'b0, 9);
    run("divu", 4'hD, 8'hC8, 8'h07, 1'b0, 8'h1C, 1'b0, 1'b0, 1'b0, 9);
    run("remu", 4'hE, 8'hC8, 8'h07, 1'b0, 8'h04, 1'b0, 1'b0, 1'b0, 9);
    run("div0", 4'hD, 8'h2A, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 9);
    run("rem0", 4'hE, 8'h2A, 8'h00, 1'b0, 8'h2A, 1'b0, 1'b1, 1'b0, 9);
    run("ill",  4'hF, 8'h55, 8'hAA, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1);

    // Every opcode against a small operand table; checked by the model.
    for (int o = 0; o < 16; o++) begin
      for (int i = 0; i < 5; i++) begin
        send(4'(o), pa[i], pb[i], 1'(i % 2));
        wait_out(lat);
      end
    end

    // Backpressure: result held, second request stalled until consumed.
    @(posedge clk); #1;
    out_ready = 1'b0; op = 4'h0; a = 8'h10; b = 8'h20; cin = 1'b0; in_valid = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!in_ready && t < 50);
    @(posedge clk); #1;
    op = 4'h5; a = 8'h0F; b = 8'hF0;
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid",    32'(out_valid), 32'(1));
      chk("bp_in_ready", 32'(in_ready),  32'(0));
      chk("bp_result",   32'(result),    32'(8'h30));
    end
    @(posedge clk); #1 out_ready = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!in_ready && t < 20);
    @(posedge clk); #1 in_valid = 1'b0;
    wait_out(lat);
    chk("bp_second_lat", 32'(lat),    32'(1));
    chk("bp_second_res", 32'(result), 32'(8'hFF));

    // Reset in the middle of a multiply discards it.
    send(4'hC, 8'h12, 8'h10, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst2_in_ready",  32'(in_ready),  32'(1));
    chk("rst2_out_valid", 32'(out_valid), 32'(0));
    chk("rst2_result",    32'(result),    32'(0));
    chk("rst2_flags",     32'({carry, overflow, zero}), 32'(0));
    repeat (12) begin
      @(negedge clk);
      chk("rst2_no_valid", 32'(out_valid), 32'(0));
    end
    run("mul_after_rst", 4'hC, 8'h0F, 8'h0F, 1'b0, 8'hE1, 1'b0, 1'b0, 1'b0, 9);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
